// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises ps2_clk/ps2_dat, deserialises
// 11-bit frames and buffers good bytes in a show-ahead FIFO with sticky error flags.
module ps2_rx #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          ps2_clk,
    input  logic                          ps2_dat,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_n;
    logic          clk_meta, clk_sync, clk_prev;
    logic          dat_meta, dat_sync;
    logic          clk_fall;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          parity, parity_n;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;
    logic          push_n, push_pend;
    logic [7:0]    push_byte;
    logic          err_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          fifo_full;
    logic          rd_fire, wr_fire, ovf_set;

    // Synchronisers idle at the bus-high level so reset never fakes an edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || clk_fall) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !clk_fall && (tmo_cnt >= TW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            push_pend <= 1'b0;
            push_byte <= '0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            parity    <= parity_n;
            push_pend <= push_n;
            push_byte <= shift;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity;
        push_n    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (clk_fall && !dat_sync) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (timeout) begin
                    state_n = IDLE;
                    err_set = 1'b1;
                end else if (clk_fall) begin
                    shift_n[bit_cnt] = dat_sync;
                    bit_cnt_n        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (timeout) begin
                    state_n = IDLE;
                    err_set = 1'b1;
                end else if (clk_fall) begin
                    parity_n = dat_sync;
                    state_n  = STOP;
                end
            end
            STOP: begin
                if (timeout) begin
                    state_n = IDLE;
                    err_set = 1'b1;
                end else if (clk_fall) begin
                    // Odd parity: data XOR parity must be 1.
                    if (dat_sync && ((^shift) ^ parity)) begin
                        push_n = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fifo_full = (fifo_count == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
    assign rd_valid  = (fifo_count != '0);
    assign rd_fire   = rd_en && rd_valid;
    // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
    assign wr_fire   = push_pend && (!fifo_full || rd_fire);
    assign ovf_set   = push_pend && fifo_full && !rd_fire;

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem[wr_ptr] <= push_byte;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frame-level reference model with a queue of
// expected bytes, compared against the DUT outputs on every core cycle.
module tb_ps2_rx;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 4096;

    logic       clock = 1'b0;
    logic       resetn;
    logic       ps2_clk, ps2_dat;
    logic       rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] fifo_count;
    logic       frame_err, overflow;

    ps2_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd_en(rd_en), .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        bit          is_err;
        logic [7:0]  val;
    } ev_t;

    int unsigned n_vec = 0, n_mis = 0;
    int unsigned cyc = 0;
    int unsigned last_fall = 0;
    int unsigned dc_lo = 0, dc_hi = 0;
    int unsigned pop_cyc[$];
    int unsigned clr_cyc[$];
    ev_t         ev[$];
    logic [7:0]  mq[$];
    bit          m_err = 0, m_ovf = 0;

    // Strobes are driven from one place; other code only books future cycles.
    always @(negedge clock) begin
        rd_en   = 1'b0;
        err_clr = 1'b0;
        foreach (pop_cyc[i]) if (pop_cyc[i] == cyc) rd_en = 1'b1;
        foreach (clr_cyc[i]) if (clr_cyc[i] == cyc) err_clr = 1'b1;
    end

    always begin
        bit en, clr, full_pre, popped, v;
        logic [7:0] d;
        @(posedge clock);
        cyc = cyc + 1;
        en  = rd_en;
        clr = err_clr;
        #1;
        if (!resetn) begin
            mq.delete();
            ev.delete();
            m_err = 0;
            m_ovf = 0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            popped   = en && (mq.size() != 0);
            if (popped) void'(mq.pop_front());
            if (clr) begin
                m_err = 0;
                m_ovf = 0;
            end
            for (int i = int'(ev.size()) - 1; i >= 0; i--) begin
                if (ev[i].due == cyc) begin
                    if (ev[i].is_err) m_err = 1;
                    else if (full_pre && !popped) m_ovf = 1;
                    else mq.push_back(ev[i].val);
                    ev.delete(i);
                end
            end
        end
        v = (mq.size() != 0);
        d = v ? mq[0] : 8'h00;
        n_vec++;
        if (rd_valid !== v || fifo_count !== 4'(mq.size()) || overflow !== m_ovf ||
            ((!resetn || v) && rd_data !== d) ||
            (!(cyc >= dc_lo && cyc <= dc_hi) && frame_err !== m_err)) begin
            n_mis++;
            $display("FAIL cycle %0d outputs: got valid=%0b data=%02h count=%0d err=%0b ovf=%0b, expected valid=%0b data=%02h count=%0d err=%0b ovf=%0b",
                     cyc, rd_valid, rd_data, fifo_count, frame_err, overflow,
                     v, d, mq.size(), m_err, m_ovf);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int unsigned hp();
        return $urandom_range(5, 2);
    endfunction

    // nbits < 11 sends a truncated frame; pop_at_push books a pop on the push cycle.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit pop_at_push);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = ~(^b) ^ bad_par;
        f[10]   = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (hp()) step();
            ps2_clk   = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                if (f[10] && ((^f[8:1]) ^ f[9])) begin
                    ev.push_back('{due: cyc + 4, is_err: 1'b0, val: b});
                    if (pop_at_push) pop_cyc.push_back(cyc + 3);
                end else begin
                    ev.push_back('{due: cyc + 3, is_err: 1'b1, val: 8'h00});
                end
            end
            repeat (hp()) step();
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (8) step();
    endtask

    task automatic pop();
        pop_cyc.push_back(cyc + 1);
        repeat (3) step();
    endtask

    task automatic clear_flags();
        clr_cyc.push_back(cyc + 1);
        repeat (3) step();
    endtask

    initial begin
        resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (4) step();
        chk("reset_valid", rd_valid, 0);
        chk("reset_data", rd_data, 8'h00);
        chk("reset_err", frame_err, 0);
        resetn = 1'b1;
        repeat (3) step();

        // Idle line with fastest clock and data high.
        for (int i = 0; i < 2500; i++) begin
            ps2_clk = 1'b1; repeat (2) step();
            ps2_clk = 1'b0; repeat (2) step();
        end
        ps2_clk = 1'b1;
        repeat (4) step();
        chk("idle_valid", rd_valid, 0);
        chk("idle_count", fifo_count, 0);
        chk("idle_err", frame_err, 0);
        chk("idle_ovf", overflow, 0);

        send_frame(8'h1C, 0, 0, 11, 0);
        send_frame(8'hF0, 0, 0, 11, 0);
        send_frame(8'h1C, 0, 0, 11, 0);
        chk("good_count", fifo_count, 3);
        chk("good_head", rd_data, 8'h1C);
        chk("good_valid", rd_valid, 1);
        pop();
        chk("good_pop1", rd_data, 8'hF0);
        pop();
        chk("good_pop2", rd_data, 8'h1C);
        pop();
        chk("good_empty", rd_valid, 0);
        chk("good_err", frame_err, 0);

        send_frame(8'h1C, 1, 0, 11, 0);
        chk("parity_err", frame_err, 1);
        chk("parity_count", fifo_count, 0);
        clear_flags();
        chk("clr_err", frame_err, 0);
        send_frame(8'h5A, 0, 1, 11, 0);
        chk("stop_err", frame_err, 1);
        chk("stop_count", fifo_count, 0);

        clear_flags();
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, 11, 0);
        chk("ovf_count", fifo_count, 8);
        chk("ovf_flag", overflow, 1);
        for (int k = 1; k <= 8; k++) begin
            chk("ovf_pop", rd_data, k);
            pop();
        end
        chk("ovf_empty", rd_valid, 0);
        clear_flags();
        chk("ovf_clr", overflow, 0);
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, 11, k == 9);
        chk("pp_count", fifo_count, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", rd_data, 8'h02);
        repeat (7) pop();
        chk("pp_last", rd_data, 8'h09);
        pop();
        chk("pp_empty", rd_valid, 0);

        clear_flags();
        chk("tmo_pre", frame_err, 0);
        send_frame(8'h5A, 0, 0, 6, 0);
        ev.push_back('{due: last_fall + 3 + TMO, is_err: 1'b1, val: 8'h00});
        dc_lo = last_fall + 1 + TMO;
        dc_hi = last_fall + 5 + TMO;
        repeat (TMO + 20) step();
        chk("tmo_err", frame_err, 1);
        send_frame(8'h5A, 0, 0, 11, 0);
        chk("tmo_next", rd_data, 8'h5A);
        chk("tmo_count", fifo_count, 1);

        send_frame(8'h33, 0, 0, 5, 0);
        resetn = 1'b0;
        repeat (5) step();
        resetn = 1'b1;
        repeat (3) step();
        send_frame(8'h29, 0, 0, 11, 0);
        chk("rst_count", fifo_count, 1);
        chk("rst_data", rd_data, 8'h29);
        chk("rst_err", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        pop();

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3, 0) == 0) pop_cyc.push_back(cyc + $urandom_range(120, 1));
            if ($urandom_range(3, 0) == 0) pop_cyc.push_back(cyc + $urandom_range(120, 1));
            if ($urandom_range(7, 0) == 0) clr_cyc.push_back(cyc + $urandom_range(120, 1));
            send_frame(8'($urandom), $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, 11, 0);
        end
        repeat (200) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
